// File: rtl/comp_mult_job_ctrl.sv
// Job sequencer for the complex-multiplier register file: queues descriptors, programs, starts and polls each job.
// Optional POLL-latency capture on last_lat is enabled with `define COMP_MULT_JOB_LAT_EN.
module comp_mult_job_ctrl #(
    parameter int                SYS_AW     = 32,
    parameter int                REG_DW     = 32,
    parameter logic [SYS_AW-1:0] RF_BADDR   = '0,
    parameter int                FIFO_DEPTH = 4,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              sw_rst,
    input  logic              job_val,
    output logic              job_rdy,
    input  logic [SYS_AW-1:0] job_op1_addr,
    input  logic [SYS_AW-1:0] job_op2_addr,
    input  logic [SYS_AW-1:0] job_res_addr,
    input  logic [REG_DW-1:0] job_no_op,
    output logic [SYS_AW-1:0] rf_addr,
    output logic              rf_wr,
    output logic [REG_DW-1:0] rf_cfg,
    input  logic [REG_DW-1:0] rf_sts,
    output logic              busy,
    output logic              done_pulse,
    output logic [CNT_W-1:0]  jobs_done,
    output logic [CNT_W-1:0]  jobs_skipped,
    output logic [REG_DW-1:0] last_lat
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_OP1,
        ST_WR_OP2,
        ST_WR_RES,
        ST_WR_NOP,
        ST_WR_START,
        ST_POLL,
        ST_CLR_STS
    } state_t;

    function automatic logic [REG_DW-1:0] addr_to_cfg(input logic [SYS_AW-1:0] a);
        return REG_DW'(a);
    endfunction

    function automatic logic [SYS_AW-1:0] rf_reg(input int unsigned idx);
        return RF_BADDR + SYS_AW'(idx);
    endfunction

    state_t            state_q;
    logic [SYS_AW-1:0] cur_op1_q;
    logic [SYS_AW-1:0] cur_op2_q;
    logic [SYS_AW-1:0] cur_res_q;
    logic [REG_DW-1:0] cur_no_op_q;
    logic [CNT_W-1:0]  jobs_done_q;
    logic [CNT_W-1:0]  jobs_skipped_q;

    // Job queue: one storage array per descriptor field, pointers carry an extra wrap bit.
    logic [SYS_AW-1:0] op1_mem [FIFO_DEPTH];
    logic [SYS_AW-1:0] op2_mem [FIFO_DEPTH];
    logic [SYS_AW-1:0] res_mem [FIFO_DEPTH];
    logic [REG_DW-1:0] nop_mem [FIFO_DEPTH];
    logic [PW:0]       wr_ptr_q;
    logic [PW:0]       rd_ptr_q;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [SYS_AW-1:0] head_op1;
    logic [SYS_AW-1:0] head_op2;
    logic [SYS_AW-1:0] head_res;
    logic [REG_DW-1:0] head_no_op;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push       = job_val & ~fifo_full;
    assign pop        = (state_q == ST_IDLE) & ~fifo_empty;

    assign head_op1   = op1_mem[rd_ptr_q[PW-1:0]];
    assign head_op2   = op2_mem[rd_ptr_q[PW-1:0]];
    assign head_res   = res_mem[rd_ptr_q[PW-1:0]];
    assign head_no_op = nop_mem[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            op1_mem[wr_ptr_q[PW-1:0]] <= job_op1_addr;
            op2_mem[wr_ptr_q[PW-1:0]] <= job_op2_addr;
            res_mem[wr_ptr_q[PW-1:0]] <= job_res_addr;
            nop_mem[wr_ptr_q[PW-1:0]] <= job_no_op;
        end
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    // Sequencer: zero-op jobs are consumed in IDLE without touching the register bus.
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_q        <= ST_IDLE;
            cur_op1_q      <= '0;
            cur_op2_q      <= '0;
            cur_res_q      <= '0;
            cur_no_op_q    <= '0;
            jobs_done_q    <= '0;
            jobs_skipped_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        if (head_no_op == '0) begin
                            jobs_skipped_q <= jobs_skipped_q + CNT_W'(1);
                        end else begin
                            cur_op1_q   <= head_op1;
                            cur_op2_q   <= head_op2;
                            cur_res_q   <= head_res;
                            cur_no_op_q <= head_no_op;
                            state_q     <= ST_WR_OP1;
                        end
                    end
                end
                ST_WR_OP1:   state_q <= ST_WR_OP2;
                ST_WR_OP2:   state_q <= ST_WR_RES;
                ST_WR_RES:   state_q <= ST_WR_NOP;
                ST_WR_NOP:   state_q <= ST_WR_START;
                ST_WR_START: state_q <= ST_POLL;
                ST_POLL: begin
                    if (rf_sts[0]) state_q <= ST_CLR_STS;
                end
                ST_CLR_STS: begin
                    jobs_done_q <= jobs_done_q + CNT_W'(1);
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rf_wr   = 1'b0;
        rf_addr = rf_reg(5);
        rf_cfg  = '0;
        case (state_q)
            ST_WR_OP1: begin
                rf_wr   = 1'b1;
                rf_addr = rf_reg(0);
                rf_cfg  = addr_to_cfg(cur_op1_q);
            end
            ST_WR_OP2: begin
                rf_wr   = 1'b1;
                rf_addr = rf_reg(1);
                rf_cfg  = addr_to_cfg(cur_op2_q);
            end
            ST_WR_RES: begin
                rf_wr   = 1'b1;
                rf_addr = rf_reg(2);
                rf_cfg  = addr_to_cfg(cur_res_q);
            end
            ST_WR_NOP: begin
                rf_wr   = 1'b1;
                rf_addr = rf_reg(3);
                rf_cfg  = cur_no_op_q;
            end
            ST_WR_START: begin
                rf_wr   = 1'b1;
                rf_addr = rf_reg(4);
                rf_cfg  = REG_DW'(1);
            end
            ST_CLR_STS: begin
                rf_wr   = 1'b1;
                rf_addr = rf_reg(5);
                rf_cfg  = '0;
            end
            default: begin
                rf_wr   = 1'b0;
                rf_addr = rf_reg(5);
                rf_cfg  = '0;
            end
        endcase
    end

    assign job_rdy      = ~fifo_full;
    assign busy         = (state_q != ST_IDLE) | ~fifo_empty;
    assign done_pulse   = (state_q == ST_CLR_STS);
    assign jobs_done    = jobs_done_q;
    assign jobs_skipped = jobs_skipped_q;

    logic unused_sts;
    assign unused_sts = ^rf_sts[REG_DW-1:1];

`ifdef COMP_MULT_JOB_LAT_EN
    function automatic logic [REG_DW-1:0] sat_inc(input logic [REG_DW-1:0] v);
        return (&v) ? v : v + REG_DW'(1);
    endfunction

    logic [REG_DW-1:0] lat_cnt_q;
    logic [REG_DW-1:0] last_lat_q;

    // The capture includes the POLL cycle that saw done, so last_lat counts POLL cycles.
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            lat_cnt_q  <= '0;
            last_lat_q <= '0;
        end else begin
            if (state_q == ST_WR_START) begin
                lat_cnt_q <= '0;
            end else if (state_q == ST_POLL) begin
                lat_cnt_q <= sat_inc(lat_cnt_q);
                if (rf_sts[0]) last_lat_q <= sat_inc(lat_cnt_q);
            end
        end
    end

    assign last_lat = last_lat_q;
`else
    assign last_lat = '0;
`endif

endmodule

// File: tb/tb_comp_mult_job_ctrl.sv
// Directed bench for comp_mult_job_ctrl with a small multiplier-register target model.
module tb_comp_mult_job_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;
`ifdef COMP_MULT_JOB_LAT_EN
    localparam int LAT_EN = 1;
`else
    localparam int LAT_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          sw_rst = 1'b1;
    logic          job_val = 1'b0;
    logic          job_rdy;
    logic [AW-1:0] job_op1_addr = '0;
    logic [AW-1:0] job_op2_addr = '0;
    logic [AW-1:0] job_res_addr = '0;
    logic [DW-1:0] job_no_op = '0;
    logic [AW-1:0] rf_addr;
    logic          rf_wr;
    logic [DW-1:0] rf_cfg;
    logic [DW-1:0] rf_sts;
    logic          busy;
    logic          done_pulse;
    logic [CW-1:0] jobs_done;
    logic [CW-1:0] jobs_skipped;
    logic [DW-1:0] last_lat;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    logic [63:0] wlog[$];

    // Target: start write arms a countdown; done holds while armed, count is 0 and not held off.
    logic armed = 1'b0;
    int   tcnt  = 0;
    int   delay = 0;
    logic hold  = 1'b0;

    comp_mult_job_ctrl dut (
        .clk         (clk),
        .sw_rst      (sw_rst),
        .job_val     (job_val),
        .job_rdy     (job_rdy),
        .job_op1_addr(job_op1_addr),
        .job_op2_addr(job_op2_addr),
        .job_res_addr(job_res_addr),
        .job_no_op   (job_no_op),
        .rf_addr     (rf_addr),
        .rf_wr       (rf_wr),
        .rf_cfg      (rf_cfg),
        .rf_sts      (rf_sts),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .jobs_done   (jobs_done),
        .jobs_skipped(jobs_skipped),
        .last_lat    (last_lat)
    );

    always #5 clk = ~clk;

    assign rf_sts = {{(DW-1){1'b0}}, (armed && tcnt == 0 && !hold)};

    always @(posedge clk) begin
        if (sw_rst) begin
            armed <= 1'b0;
            tcnt  <= 0;
        end else if (rf_wr && rf_addr == 32'd4 && rf_cfg[0]) begin
            armed <= 1'b1;
            tcnt  <= delay;
        end else if (rf_wr && rf_addr == 32'd5) begin
            armed <= 1'b0;
        end else if (tcnt > 0) begin
            tcnt <= tcnt - 1;
        end
    end

    always @(negedge clk) begin
        if (!sw_rst) begin
            if (rf_wr) wlog.push_back({rf_addr, rf_cfg});
            if (done_pulse) n_done++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        sw_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sw_rst = 1'b0;
        wlog.delete();
        n_done = 0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [31:0] n);
        job_val      = 1'b1;
        job_op1_addr = a;
        job_op2_addr = b;
        job_res_addr = r;
        job_no_op    = n;
        @(posedge clk);
        #1;
        job_val = 1'b0;
    endtask

    task automatic wait_jobs(input int target, input int budget);
        int c;
        c = 0;
        while (n_done < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        @(negedge clk);
        #1;
        chk("wait_jobs_timeout", (n_done >= target), 1);
    endtask

    initial begin
        int c;
        logic [31:0] exp_cfg [5];
        logic [31:0] op1_seen [$];
        logic        rdy_seen [6];

        exp_cfg[0] = 32'h10; exp_cfg[1] = 32'h20; exp_cfg[2] = 32'h40;
        exp_cfg[3] = 32'h2;  exp_cfg[4] = 32'h1;

        // Reset state
        apply_reset();
        chk("rst_job_rdy", job_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done_pulse", done_pulse, 0);
        chk("rst_rf_wr", rf_wr, 0);
        chk("rst_rf_addr", rf_addr, 5);
        chk("rst_rf_cfg", rf_cfg, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_jobs_skipped", jobs_skipped, 0);
        chk("rst_last_lat", last_lat, 0);

        // Single job, done 30 POLL cycles after the first poll
        delay = 29;
        push(32'h10, 32'h20, 32'h40, 32'h2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("single_wr%0d_rf_wr", k), rf_wr, 1);
            chk($sformatf("single_wr%0d_addr", k), rf_addr, k);
            chk($sformatf("single_wr%0d_cfg", k), rf_cfg, exp_cfg[k]);
        end
        @(posedge clk);
        #1;
        chk("single_poll_rf_wr", rf_wr, 0);
        chk("single_poll_addr", rf_addr, 5);
        chk("single_poll_busy", busy, 1);
        c = 7;
        while (!done_pulse && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("single_done_cycle", c, 37);
        chk("single_clr_rf_wr", rf_wr, 1);
        chk("single_clr_addr", rf_addr, 5);
        chk("single_clr_cfg", rf_cfg, 0);
        @(posedge clk);
        #1;
        chk("single_pulse_once", done_pulse, 0);
        chk("single_jobs_done", jobs_done, 1);
        chk("single_last_lat", last_lat, (LAT_EN != 0) ? 30 : 0);
        chk("single_wlog_size", wlog.size(), 6);
        chk("single_busy_after", busy, 0);

        // Zero-op job followed by a normal job; done already high at first POLL
        apply_reset();
        delay = 0;
        push(32'hAAA, 32'hBBB, 32'hCCC, 32'h0);
        push(32'h111, 32'h222, 32'h333, 32'h1);
        wait_jobs(1, 60);
        chk("zero_jobs_skipped", jobs_skipped, 1);
        chk("zero_jobs_done", jobs_done, 1);
        chk("zero_wlog_size", wlog.size(), 6);
        if (wlog.size() == 6) begin
            chk("zero_first_write", wlog[0], {32'd0, 32'h111});
            chk("zero_nop_write", wlog[3], {32'd3, 32'h1});
        end
        chk("zero_last_lat", last_lat, (LAT_EN != 0) ? 1 : 0);

        // Queue full: target stalls done while six jobs are pushed back-to-back
        apply_reset();
        delay = 0;
        hold  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            job_val      = 1'b1;
            job_op1_addr = 32'h100 + i;
            job_op2_addr = 32'h200 + i;
            job_res_addr = 32'h300 + i;
            job_no_op    = i + 1;
            rdy_seen[i]  = job_rdy;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 6; i++) chk($sformatf("qf_rdy%0d", i), rdy_seen[i], (i < 5));
        repeat (10) @(posedge clk);
        #1;
        chk("qf_stall_rdy", job_rdy, 0);
        chk("qf_stall_jobs_done", jobs_done, 0);
        hold = 1'b0;
        c = 0;
        while (!job_rdy && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("qf_j6_rdy_timeout", job_rdy, 1);
        chk("qf_done_at_j6", jobs_done, 1);
        @(posedge clk);
        #1;
        job_val = 1'b0;
        wait_jobs(6, 200);
        @(posedge clk);
        #1;
        chk("qf_jobs_done", jobs_done, 6);
        foreach (wlog[i]) if (wlog[i][63:32] == 32'd0) op1_seen.push_back(wlog[i][31:0]);
        chk("qf_op1_count", op1_seen.size(), 6);
        foreach (op1_seen[i]) chk($sformatf("qf_order%0d", i), op1_seen[i], 32'h100 + i);

        // Reset mid-POLL with two jobs still queued
        hold = 1'b1;
        push(32'h400, 32'h401, 32'h402, 32'h1);
        push(32'h410, 32'h411, 32'h412, 32'h1);
        push(32'h420, 32'h421, 32'h422, 32'h1);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_in_poll_addr", rf_addr, 5);
        chk("mid_in_poll_rf_wr", rf_wr, 0);
        chk("mid_busy_before", busy, 1);
        chk("mid_jobs_done_before", jobs_done, 6);
        wlog.delete();
        sw_rst = 1'b1;
        @(posedge clk);
        #1;
        sw_rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_job_rdy", job_rdy, 1);
        chk("mid_jobs_done", jobs_done, 0);
        chk("mid_jobs_skipped", jobs_skipped, 0);
        chk("mid_rf_wr", rf_wr, 0);
        chk("mid_rf_addr", rf_addr, 5);
        chk("mid_last_lat", last_lat, 0);
        hold = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_no_writes", wlog.size(), 0);
        chk("mid_busy_later", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
